// File: rtl/mux_n_1_pipe_pkg.sv
// Shared parameters and elaboration helpers for the pipelined N:1 multiplexer.
package mux_n_1_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N_CH  = 4;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_pipe_level.sv
// One registered level of the mux tree: N_IN inputs paired into N_IN/2 outputs
// using select bit LEVEL; valid and the full select travel alongside the data.
module mux_pipe_level
    import mux_n_1_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_IN  = DEF_N_CH,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned LEVEL = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          advance,
    input  logic [N_IN*WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic [SEL_W-1:0]              in_sel,
    output logic [(N_IN/2)*WIDTH-1:0]     out_data,
    output logic                          out_valid,
    output logic [SEL_W-1:0]              out_sel
);

    localparam int unsigned N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] mux_c;

    // Pair (2i, 2i+1) picks the odd channel when this level's select bit is set.
    always_comb begin
        mux_c = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            mux_c[i*WIDTH +: WIDTH] = in_sel[LEVEL] ? in_data[(2*i+1)*WIDTH +: WIDTH]
                                                    : in_data[(2*i)*WIDTH +: WIDTH];
        end
    end

    // Payload only loads on a valid slot so the output holds the last item through bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= mux_c;
                out_sel  <= in_sel;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Pipelined N:1 multiplexer: a binary tree of registered 2:1 levels sharing a
// single advance signal, with valid/ready handshaking on both sides.
module mux_n_1_pipe
    import mux_n_1_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned N_CH  = DEF_N_CH,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (!is_pow2(N_CH) || (N_CH < 2) || (WIDTH < 1)) begin : g_bad_param
        $fatal(1, "mux_n_1_pipe: N_CH must be a power of two >= 2 and WIDTH >= 1");
    end

    logic advance;

    // Whole pipeline moves in lockstep; it only freezes when the output is held.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int unsigned N_IN = N_CH >> k;

        logic [N_IN*WIDTH-1:0]     d_in;
        logic                      v_in;
        logic [SEL_W-1:0]          s_in;
        logic [(N_IN/2)*WIDTH-1:0] d_out;
        logic                      v_out;
        logic [SEL_W-1:0]          s_out;

        if (k == 0) begin : g_src
            assign d_in = in_data;
            assign v_in = in_valid & advance;
            assign s_in = in_sel;
        end else begin : g_src
            assign d_in = g_lvl[k-1].d_out;
            assign v_in = g_lvl[k-1].v_out;
            assign s_in = g_lvl[k-1].s_out;
        end

        mux_pipe_level #(
            .WIDTH (WIDTH),
            .N_IN  (N_IN),
            .SEL_W (SEL_W),
            .LEVEL (k)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_data   (d_in),
            .in_valid  (v_in),
            .in_sel    (s_in),
            .out_data  (d_out),
            .out_valid (v_out),
            .out_sel   (s_out)
        );
    end

    assign out_data  = g_lvl[SEL_W-1].d_out;
    assign out_valid = g_lvl[SEL_W-1].v_out;
    assign out_sel   = g_lvl[SEL_W-1].s_out;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Scoreboard bench for mux_n_1_pipe: a 4x8 instance for directed cases and an
// 8x16 instance for scaling and a random valid/ready soak.
module tb_mux_n_1_pipe;

    localparam int unsigned AW = 8;
    localparam int unsigned AN = 4;
    localparam int unsigned AS = 2;
    localparam int unsigned BW = 16;
    localparam int unsigned BN = 8;
    localparam int unsigned BS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AN*AW-1:0] a_in_data;
    logic [AS-1:0]    a_in_sel;
    logic             a_in_valid, a_in_ready;
    logic [AW-1:0]    a_out_data;
    logic [AS-1:0]    a_out_sel;
    logic             a_out_valid, a_out_ready;

    logic [BN*BW-1:0] b_in_data;
    logic [BS-1:0]    b_in_sel;
    logic             b_in_valid, b_in_ready;
    logic [BW-1:0]    b_out_data;
    logic [BS-1:0]    b_out_sel;
    logic             b_out_valid, b_out_ready;

    mux_n_1_pipe #(.WIDTH(AW), .N_CH(AN)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_n_1_pipe #(.WIDTH(BW), .N_CH(BN)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  sel;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_a = 1'b0;
    bit   lat_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: scoreboard pop on output transfer, handshake and hold-stability checks.
    logic          a_pv = 1'b0, a_pr = 1'b0, a_prst = 1'b0;
    logic [AW-1:0] a_pd = '0;
    logic [AS-1:0] a_ps = '0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        #2;
        check("a_in_ready", 32'(a_in_ready), 32'(!a_out_valid || a_out_ready));
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_out", 32'(a_out_data), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                check("a_data", 32'(a_out_data), 32'(e.data));
                check("a_sel", 32'(a_out_sel), 32'(e.sel));
                if (e.lat) check("a_latency", 32'(cyc - e.cyc), 32'(AS));
            end
        end
        if (a_pv && !a_pr && a_prst && rst_n) begin
            check("a_hold_valid", 32'(a_out_valid), 32'd1);
            check("a_hold_data", 32'(a_out_data), 32'(a_pd));
            check("a_hold_sel", 32'(a_out_sel), 32'(a_ps));
        end
        a_pv = a_out_valid; a_pr = a_out_ready; a_prst = rst_n;
        a_pd = a_out_data;  a_ps = a_out_sel;
    end

    // Monitor B: same scoreboard discipline for the 8-channel instance.
    logic          b_pv = 1'b0, b_pr = 1'b0, b_prst = 1'b0;
    logic [BW-1:0] b_pd = '0;
    logic [BS-1:0] b_ps = '0;
    always @(negedge clk) begin : mon_b
        exp_t e;
        #2;
        check("b_in_ready", 32'(b_in_ready), 32'(!b_out_valid || b_out_ready));
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_out", 32'(b_out_data), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                check("b_data", 32'(b_out_data), 32'(e.data));
                check("b_sel", 32'(b_out_sel), 32'(e.sel));
                if (e.lat) check("b_latency", 32'(cyc - e.cyc), 32'(BS));
            end
        end
        if (b_pv && !b_pr && b_prst && rst_n) begin
            check("b_hold_valid", 32'(b_out_valid), 32'd1);
            check("b_hold_data", 32'(b_out_data), 32'(b_pd));
            check("b_hold_sel", 32'(b_out_sel), 32'(b_ps));
        end
        b_pv = b_out_valid; b_pr = b_out_ready; b_prst = rst_n;
        b_pd = b_out_data;  b_ps = b_out_sel;
    end

    // One cycle on A starting at a falling edge; pushes the expectation if accepted.
    task automatic cyc_a(input logic v, input logic [AN*AW-1:0] d, input logic [AS-1:0] s,
                         input logic r, output bit acc);
        exp_t e;
        a_in_valid = v; a_in_data = d; a_in_sel = s; a_out_ready = r;
        #1;
        acc = v && a_in_ready;
        if (acc) begin
            e.data = 16'(d[int'(s)*AW +: AW]);
            e.sel  = 3'(s);
            e.cyc  = cyc;
            e.lat  = lat_a;
            qa.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic v, input logic [BN*BW-1:0] d, input logic [BS-1:0] s,
                         input logic r, output bit acc);
        exp_t e;
        b_in_valid = v; b_in_data = d; b_in_sel = s; b_out_ready = r;
        #1;
        acc = v && b_in_ready;
        if (acc) begin
            e.data = d[int'(s)*BW +: BW];
            e.sel  = s;
            e.cyc  = cyc;
            e.lat  = lat_b;
            qb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send_a(input logic [AN*AW-1:0] d, input logic [AS-1:0] s);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cyc_a(1'b1, d, s, 1'b1, acc);
        check("a_send_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_b_rand(input logic [BN*BW-1:0] d, input logic [BS-1:0] s);
        bit acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++)
            cyc_b(1'b1, d, s, logic'($urandom_range(0, 9) < 7), acc);
        check("b_send_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && !a_out_valid && !b_out_valid) break;
            idle();
        end
        check("drain_empty", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] VEC_A = 32'hDDCC_BBAA;

    initial begin : stim
        bit acc;
        logic [BN*BW-1:0] bvec;
        logic [BS-1:0]    bs;

        a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = 1'b1;

        // Reset held for three rising edges.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_data", 32'(a_out_data), 32'h00);
        check("rst_a_sel", 32'(a_out_sel), 32'd0);
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        check("rst_b_data", 32'(b_out_data), 32'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Full select sweep at full throughput, latency checked.
        lat_a = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cyc_a(1'b1, VEC_A, AS'(s), 1'b1, acc);
            check("sweep_accept", 32'(acc), 32'd1);
        end
        drain();

        // Backpressure: two items in, then a five-cycle stall with a third item waiting.
        lat_a = 1'b0;
        cyc_a(1'b1, VEC_A, 2'd3, 1'b1, acc);
        cyc_a(1'b1, VEC_A, 2'd2, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_data = VEC_A; a_in_sel = 2'd1; a_out_ready = 1'b0;
            #1;
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_out_data", 32'(a_out_data), 32'hDD);
            @(negedge clk);
        end
        send_a(VEC_A, 2'd1);
        send_a(VEC_A, 2'd0);
        drain();

        // Bubbles: valid pattern 1,0,1 must emerge as 1,0,1.
        lat_a = 1'b1;
        cyc_a(1'b1, VEC_A, 2'd1, 1'b1, acc);
        check("bub_lat_gap", 32'(a_out_valid), 32'd0);
        cyc_a(1'b0, VEC_A, 2'd0, 1'b1, acc);
        check("bub_first_valid", 32'(a_out_valid), 32'd1);
        check("bub_first_data", 32'(a_out_data), 32'hBB);
        cyc_a(1'b1, VEC_A, 2'd2, 1'b1, acc);
        check("bub_gap_valid", 32'(a_out_valid), 32'd0);
        check("bub_gap_hold", 32'(a_out_data), 32'hBB);
        cyc_a(1'b0, VEC_A, 2'd0, 1'b1, acc);
        check("bub_second_valid", 32'(a_out_valid), 32'd1);
        check("bub_second_data", 32'(a_out_data), 32'hCC);
        drain();

        // Reset mid-stream with two items in flight; neither may appear afterwards.
        lat_a = 1'b0;
        cyc_a(1'b1, VEC_A, 2'd0, 1'b1, acc);
        cyc_a(1'b1, VEC_A, 2'd3, 1'b1, acc);
        rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        qa.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data", 32'(a_out_data), 32'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("post_rst_valid", 32'(a_out_valid), 32'd0);
        end

        // Scaling instance: channel c carries 0x1000+c, select sweeps 0..7.
        for (int c = 0; c < 8; c++) bvec[c*BW +: BW] = 16'h1000 + 16'(c);
        lat_b = 1'b1;
        for (int s = 0; s < 8; s++) begin
            cyc_b(1'b1, bvec, BS'(s), 1'b1, acc);
            check("b_sweep_accept", 32'(acc), 32'd1);
        end
        drain();

        // Random valid/ready soak on the scaling instance.
        lat_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < 8; c++) bvec[c*BW +: BW] = 16'($urandom);
            bs = BS'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                cyc_b(1'b0, bvec, bs, logic'($urandom_range(0, 1)), acc);
            send_b_rand(bvec, bs);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_1_pipe.md
# mux_n_1_pipe

Parametrised, pipelined N:1 multiplexer with a valid/ready handshake, built as a binary tree of registered 2:1 stages. It generalises the combinational 2:1 and 4:1 multiplexers to arbitrary data width and any power-of-two channel count. A registered pipeline level after each tree level keeps timing closed at large N. It sits between multi-source datapaths and a single downstream consumer that may apply backpressure.

## Interface
- WIDTH, 8, data width per channel (≥1)
- N_CH, 4, number of input channels; power of two, ≥2
- SEL_W (localparam), $clog2(N_CH), select width; also the pipeline depth in cycles
- clk  in  1  clock; all logic is on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_sel  in  SEL_W  channel to forward
- in_valid  in  1  in_data/in_sel are valid this cycle
- in_ready  out  1  block accepts input this cycle
- out_data  out  WIDTH  selected channel data
- out_sel  out  SEL_W  in_sel value that accompanied out_data
- out_valid  out  1  out_data/out_sel are valid
- out_ready  in  1  consumer accepts output this cycle

## Operation
- Tree level k (k = 0..SEL_W-1) has N_CH>>(k+1) 2:1 muxes, selected by sel bit k, LSB first.
  - Level 0 pairs channels (0,1), (2,3), and so on using sel[0]. The last level uses sel[SEL_W-1].
- Each level registers its data outputs and carries a valid bit and the full sel value to the next level.
- Global advance = out_ready | ~out_valid. All stages shift together when advance=1 and all hold when advance=0.
- in_ready = advance. This is combinational from out_ready and out_valid, with no path from in_valid.
- An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- On advance, stage k's valid loads stage k-1's valid; stage 0 loads in_valid & in_ready.
- A stage's data and sel registers load only when advance=1 and the incoming valid=1. Otherwise they hold.
  - Consequently out_data and out_sel keep the last transferred value while out_valid=0.
- Bubbles (invalid slots) propagate through the pipeline and are not collapsed.
- in_sel is always in range because N_CH is a power of two. No error path exists.

## Timing
- Reset (rst_n=0 at a clk edge): every stage valid bit, data register and sel register goes to 0.
  - Resulting output values: out_valid=0, out_data=0, out_sel=0.
  - in_ready=1 in the first cycle after reset, since out_valid=0.
- Reset mid-stream discards all in-flight items. Nothing is emitted for them after reset releases.
- Latency is SEL_W cycles from input transfer to out_valid=1 with out_ready held high (2 cycles for N_CH=4).
- Throughput is one item per cycle when out_ready=1 continuously.
- Backpressure:
  - out_ready=0 with out_valid=1 freezes the whole pipeline and drives in_ready=0.
  - out_data, out_sel and out_valid stay stable until the output transfer.
- In-flight capacity is SEL_W items. No item is dropped or duplicated under any out_ready pattern.
- out_ready=0 with out_valid=0 still advances the pipeline, filling the bubble at the output.
- Simultaneous input and output transfers in one cycle are legal and are the steady-state case.

## Structure
- No shared package is needed. SEL_W is derived locally with $clog2.
- Add an elaboration-time check that N_CH is a power of two and ≥2. A failed check is a fatal error.
- The natural sub-module is mux_pipe_level, parametrised by WIDTH, N_IN and SEL_W.
  - It takes N_IN inputs plus valid and sel, and produces N_IN/2 registered outputs plus valid and sel.
  - It uses the sel bit given by a LEVEL parameter.
- The top instantiates SEL_W levels in a generate loop and computes the shared advance and in_ready logic.

## Test plan
- Reset check (N_CH=4, WIDTH=8): hold rst_n=0 for 3 cycles → out_valid=0, out_data=0x00, out_sel=0; then in_ready=1.
- Full select sweep: in_data={0xDD,0xCC,0xBB,0xAA} (ch3..ch0), in_sel=0,1,2,3 on consecutive cycles, out_ready=1 → out_data=0xAA,0xBB,0xCC,0xDD on cycles 2,3,4,5 after the first input, with out_sel matching.
- Backpressure: stream 4 items, out_ready=0 for 5 cycles once out_valid=1 → in_ready=0 and out_data stable throughout; all 4 items then emerge in order with no loss or duplication.
- Bubbles: in_valid pattern 1,0,1 with out_ready=1 → out_valid pattern 1,0,1 after a 2-cycle latency; out_data holds the first item during the bubble.
- Reset mid-stream: 2 items in flight, assert rst_n=0 for 1 cycle → out_valid=0 afterwards and neither item ever appears.
- Scaling (N_CH=8, WIDTH=16): channel c carries 0x1000+c and in_sel sweeps 0..7 → out_data=0x1000+sel after 3 cycles; also a random valid/ready soak checked against a scoreboard.
